// File: rtl/ip_fifo_pkg.sv
// Shared types for the arbiter-to-core input FIFO.
// Entry layout and count-width helper live here so the top and memory agree.
package ip_fifo_pkg;

    localparam int IP_FIFO_DW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MODE_1 = 2'd1,
        MODE_2 = 2'd2,
        MODE_3 = 2'd3
    } ip_mode_t;

    typedef struct packed {
        logic [IP_FIFO_DW-1:0] data;
        ip_mode_t              mode;
        logic                  last;
        logic                  src;
    } ip_fifo_entry_t;

    localparam int IP_FIFO_ENTRY_W = $bits(ip_fifo_entry_t);

    function automatic int ip_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ip_fifo_mem.sv
// Entry storage for ip_input_fifo: one write port, one async read port.
// No control here; the top decides when a write is allowed.
module ip_fifo_mem
    import ip_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  ip_fifo_entry_t wdata,
    input  logic [AW-1:0]  raddr,
    output ip_fifo_entry_t rdata
);

    ip_fifo_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/ip_input_fifo.sv
// Input buffer between the two-source arbiter and the pixel core.
// Early full with skid headroom, sticky overflow, fall-through head.
module ip_input_fifo
    import ip_fifo_pkg::*;
#(
    parameter int DW    = IP_FIFO_DW,
    parameter int DEPTH = 16,
    parameter int SKID  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DW-1:0]         slvx_data,
    input  logic                  slvx_data_valid,
    input  logic [1:0]            slvx_mode,
    input  logic                  slvx_proc_val,
    input  logic                  data_source,
    input  logic                  flush,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                  ovf_err,
    output logic [DW-1:0]         out_data,
    output logic [1:0]            out_mode,
    output logic                  out_last,
    output logic                  out_src,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = ip_cnt_w(DEPTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH - SKID);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic           rd;
    logic           wr;
    logic           ovf;
    logic           mem_we;
    ip_fifo_entry_t wr_entry;
    ip_fifo_entry_t head;

    always_comb begin
        wr_entry      = '0;
        wr_entry.data = slvx_data;
        wr_entry.mode = ip_mode_t'(slvx_mode);
        wr_entry.last = slvx_proc_val;
        wr_entry.src  = data_source;
    end

    // A read in the same cycle frees the slot, so a full FIFO still accepts.
    always_comb begin
        rd  = out_valid && out_ready;
        wr  = slvx_data_valid && ((count_q != DEPTH_C) || rd);
        ovf = slvx_data_valid && (count_q == DEPTH_C) && !rd;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | ovf;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({wr, rd})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign mem_we = wr && !flush && !rst;

    ip_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q >= FULL_C);
    assign fifo_count = count_q;
    assign ovf_err    = ovf_q;
    assign out_valid  = !fifo_empty;

    // Head fields are forced to zero when empty so stale memory never leaks.
    always_comb begin
        out_data = '0;
        out_mode = '0;
        out_last = 1'b0;
        out_src  = 1'b0;
        if (out_valid) begin
            out_data = head.data;
            out_mode = head.mode;
            out_last = head.last;
            out_src  = head.src;
        end
    end

    a_count_bound : assert property (
        @(posedge clk) disable iff (rst) count_q <= DEPTH_C
    );

    a_head_stable : assert property (
        @(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !flush) |=> $stable(out_data)
    );

endmodule

// File: tb/tb_ip_input_fifo.sv
// Bench for ip_input_fifo: table vectors, hand sequences and a
// randomized run checked against a queue-based reference model.
module tb_ip_input_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int SKID  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] slvx_data;
    logic        slvx_data_valid;
    logic [1:0]  slvx_mode;
    logic        slvx_proc_val;
    logic        data_source;
    logic        flush;
    logic        fifo_full;
    logic        fifo_empty;
    logic [4:0]  fifo_count;
    logic        ovf_err;
    logic [31:0] out_data;
    logic [1:0]  out_mode;
    logic        out_last;
    logic        out_src;
    logic        out_valid;
    logic        out_ready;

    ip_input_fifo #(.DW(DW), .DEPTH(DEPTH), .SKID(SKID)) dut (
        .clk             (clk),
        .rst             (rst),
        .slvx_data       (slvx_data),
        .slvx_data_valid (slvx_data_valid),
        .slvx_mode       (slvx_mode),
        .slvx_proc_val   (slvx_proc_val),
        .data_source     (data_source),
        .flush           (flush),
        .fifo_full       (fifo_full),
        .fifo_empty      (fifo_empty),
        .fifo_count      (fifo_count),
        .ovf_err         (ovf_err),
        .out_data        (out_data),
        .out_mode        (out_mode),
        .out_last        (out_last),
        .out_src         (out_src),
        .out_valid       (out_valid),
        .out_ready       (out_ready)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [35:0] mq[$];
    logic        m_ovf;
    logic [35:0] dut_obs[$];
    logic [35:0] in_list[$];
    logic        record;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        rdy;
        int          e_cnt;
        logic        e_full;
        logic        e_empty;
        logic        e_ovf;
        logic [31:0] e_data;
    } vec_t;

    vec_t vt[33];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    function automatic logic [1:0] tmode(input logic [31:0] d);
        return d[1:0];
    endfunction

    task automatic drive(input logic v, input logic [31:0] d,
                         input logic rdy, input logic fl);
        slvx_data_valid = v;
        slvx_data       = d;
        slvx_mode       = tmode(d);
        slvx_proc_val   = d[2];
        data_source     = d[3];
        out_ready       = rdy;
        flush           = fl;
    endtask

    // Advance the model by the rules of the block, then clock the DUT.
    task automatic cycle();
        int   pre;
        logic rdm;
        logic wrm;
        pre = mq.size();
        rdm = (pre > 0) && out_ready;
        if (record && !rst && !flush && out_valid && out_ready)
            dut_obs.push_back({out_data, out_mode, out_last, out_src});
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            if (slvx_data_valid && pre == DEPTH && !rdm) m_ovf = 1'b1;
            if (flush) begin
                mq.delete();
            end else begin
                wrm = slvx_data_valid && (pre < DEPTH || rdm);
                if (rdm) void'(mq.pop_front());
                if (wrm) begin
                    mq.push_back({slvx_data, slvx_mode,
                                  slvx_proc_val, data_source});
                    if (record) in_list.push_back(mq[$]);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [35:0] h;
        h = (mq.size() > 0) ? mq[0] : 36'd0;
        chk({tag, ".count"}, fifo_count, mq.size());
        chk({tag, ".empty"}, fifo_empty, mq.size() == 0);
        chk({tag, ".full"},  fifo_full,  mq.size() >= DEPTH - SKID);
        chk({tag, ".ovf"},   ovf_err,    m_ovf);
        chk({tag, ".valid"}, out_valid,  mq.size() > 0);
        chk({tag, ".data"},  out_data,   h[35:4]);
        chk({tag, ".mode"},  out_mode,   h[3:2]);
        chk({tag, ".last"},  out_last,   h[1]);
        chk({tag, ".src"},   out_src,    h[0]);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".count"}, fifo_count, 0);
        chk({tag, ".empty"}, fifo_empty, 1);
        chk({tag, ".full"},  fifo_full,  0);
        chk({tag, ".ovf"},   ovf_err,    0);
        chk({tag, ".valid"}, out_valid,  0);
        chk({tag, ".data"},  {out_data, out_mode, out_last, out_src}, 0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int          cnt;
        int          n;

        record = 1'b0;
        m_ovf  = 1'b0;
        rst    = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        cycle();
        cycle();
        rst = 1'b0;
        check_reset("reset");

        for (int i = 1; i <= 17; i++) begin
            cnt = (i > DEPTH) ? DEPTH : i;
            vt[i-1] = '{v: 1'b1, d: 32'(i), rdy: 1'b0, e_cnt: cnt,
                        e_full: cnt >= 14, e_empty: 1'b0,
                        e_ovf: i == 17, e_data: 32'd1};
        end
        for (int j = 1; j <= 16; j++) begin
            cnt = 16 - j;
            vt[16+j] = '{v: 1'b0, d: 32'd0, rdy: 1'b1, e_cnt: cnt,
                         e_full: cnt >= 14, e_empty: cnt == 0,
                         e_ovf: 1'b1,
                         e_data: (cnt > 0) ? 32'(j + 1) : 32'd0};
        end

        for (int k = 0; k < 33; k++) begin
            drive(vt[k].v, vt[k].d, vt[k].rdy, 1'b0);
            cycle();
            chk($sformatf("vec%0d.count", k), fifo_count, vt[k].e_cnt);
            chk($sformatf("vec%0d.full", k),  fifo_full,  vt[k].e_full);
            chk($sformatf("vec%0d.empty", k), fifo_empty, vt[k].e_empty);
            chk($sformatf("vec%0d.ovf", k),   ovf_err,    vt[k].e_ovf);
            chk($sformatf("vec%0d.data", k),  out_data,   vt[k].e_data);
            chk($sformatf("vec%0d.mode", k),  out_mode,   tmode(vt[k].e_data));
            chk($sformatf("vec%0d.last", k),  out_last,   vt[k].e_data[2]);
            chk($sformatf("vec%0d.src", k),   out_src,    vt[k].e_data[3]);
            check_model($sformatf("vec%0d.m", k));
        end

        // Flush with 5 stored and a same-cycle write; ovf_err is set here.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
            cycle();
        end
        chk("flush.pre_count", fifo_count, 5);
        drive(1'b1, 32'h77, 1'b1, 1'b1);
        cycle();
        chk("flush.count", fifo_count, 0);
        chk("flush.empty", fifo_empty, 1);
        chk("flush.ovf",   ovf_err,    1);
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        cycle();
        chk("flush.discard", out_valid, 0);
        check_model("flush.m");

        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_reset("rst2");

        // Full plus simultaneous read and write.
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
            cycle();
        end
        chk("conc.pre_count", fifo_count, 16);
        drive(1'b1, 32'hAA, 1'b1, 1'b0);
        cycle();
        chk("conc.count", fifo_count, 16);
        chk("conc.ovf",   ovf_err,    0);
        chk("conc.head",  out_data,   32'h102);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) begin
            cycle();
            check_model($sformatf("conc.drain%0d", i));
        end
        chk("conc.tail_aa", out_data, 32'hAA);
        cycle();
        chk("conc.empty", fifo_empty, 1);

        drive(1'b1, 32'h55, 1'b0, 1'b0);
        cycle();
        chk("byp.valid", out_valid, 1);
        chk("byp.data",  out_data,  32'h55);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        cycle();
        chk("byp.empty", fifo_empty, 1);

        // Pointer wrap with ready pattern 1,0,1,1.
        record = 1'b1;
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, $urandom, (i % 4) != 1, 1'b0);
            cycle();
        end
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        n = 0;
        while (!fifo_empty && n < 40) begin
            cycle();
            n++;
        end
        record = 1'b0;
        chk("wrap.drained", fifo_empty, 1);
        chk("wrap.n_in",  in_list.size(), 40);
        chk("wrap.n_out", dut_obs.size(), 40);
        for (int i = 0; i < 40; i++) begin
            if (i < in_list.size() && i < dut_obs.size())
                chk($sformatf("wrap.seq%0d", i), dut_obs[i], in_list[i]);
        end

        // Reset in the middle of traffic.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0);
            cycle();
        end
        rst = 1'b1;
        drive(1'b1, 32'h999, 1'b1, 1'b0);
        cycle();
        rst = 1'b0;
        check_reset("rst_mid");

        for (int i = 0; i < 400; i++) begin
            d   = $urandom;
            rst = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 9) < 7, d,
                  (i < 200) ? ($urandom_range(0, 9) < 3)
                            : ($urandom_range(0, 9) < 7),
                  $urandom_range(0, 49) == 0);
            cycle();
            rst = 1'b0;
            check_model($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
